// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - CPU/DMA arbiter for one shared single-port RAM with 1-cycle read latency.
// Round-robin on contention, with bounded DMA lock bursts and a saturating CPU stall counter.
module mem_port_arbiter #(
  parameter int MEMORY_WIDTH = 32,
  parameter int MAX_BURST    = 8
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      cpu_req,
  input  logic [31:0]               cpu_addr,
  input  logic [MEMORY_WIDTH-1:0]   cpu_wdata,
  input  logic [MEMORY_WIDTH/8-1:0] cpu_wb,
  output logic                      cpu_stall,
  output logic                      cpu_rvalid,
  output logic [MEMORY_WIDTH-1:0]   cpu_rdata,
  input  logic                      dma_req,
  input  logic                      dma_lock,
  input  logic [31:0]               dma_addr,
  input  logic [MEMORY_WIDTH-1:0]   dma_wdata,
  input  logic [MEMORY_WIDTH/8-1:0] dma_wb,
  output logic                      dma_gnt,
  output logic                      dma_rvalid,
  output logic [MEMORY_WIDTH-1:0]   dma_rdata,
  output logic [31:0]               mem_addr,
  output logic [MEMORY_WIDTH-1:0]   mem_wdata,
  output logic [MEMORY_WIDTH/8-1:0] mem_wb,
  input  logic [MEMORY_WIDTH-1:0]   mem_rdata,
  output logic [15:0]               stall_cnt,
  input  logic                      stall_clr
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CPU  = 2'd1,
    ST_DMA  = 2'd2
  } state_t;

  localparam logic [7:0] MAX_BURST_C = 8'(MAX_BURST);

  state_t      state_q, state_d;
  logic        last_dma_q, last_dma_d;
  logic [7:0]  burst_cnt_q, burst_cnt_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic        cpu_gnt;
  logic        dma_gnt_w;

  // No grant can be issued while reset is held, so outputs settle asynchronously.
  always_comb begin
    cpu_gnt   = 1'b0;
    dma_gnt_w = 1'b0;
    if (reset) begin
      if (state_q == ST_DMA && dma_lock && dma_req &&
          (!cpu_req || burst_cnt_q < MAX_BURST_C)) begin
        dma_gnt_w = 1'b1;
      end else if (cpu_req && dma_req) begin
        if (last_dma_q) cpu_gnt = 1'b1;
        else            dma_gnt_w = 1'b1;
      end else if (cpu_req) begin
        cpu_gnt = 1'b1;
      end else if (dma_req) begin
        dma_gnt_w = 1'b1;
      end
    end
  end

  always_comb begin
    state_d     = ST_IDLE;
    last_dma_d  = last_dma_q;
    burst_cnt_d = 8'd0;
    stall_cnt_d = stall_cnt_q;
    if (cpu_gnt) begin
      state_d    = ST_CPU;
      last_dma_d = 1'b0;
    end else if (dma_gnt_w) begin
      state_d    = ST_DMA;
      last_dma_d = 1'b1;
      if (state_q != ST_DMA)            burst_cnt_d = 8'd1;
      else if (burst_cnt_q >= MAX_BURST_C) burst_cnt_d = MAX_BURST_C;
      else                              burst_cnt_d = burst_cnt_q + 8'd1;
    end
    if (stall_clr)                             stall_cnt_d = 16'd0;
    else if (cpu_stall && stall_cnt_q != 16'hFFFF) stall_cnt_d = stall_cnt_q + 16'd1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      last_dma_q  <= 1'b1;
      burst_cnt_q <= 8'd0;
      stall_cnt_q <= 16'd0;
    end else begin
      state_q     <= state_d;
      last_dma_q  <= last_dma_d;
      burst_cnt_q <= burst_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // The previous cycle's grant owner is also the owner of this cycle's RAM response.
  assign cpu_rvalid = (state_q == ST_CPU);
  assign dma_rvalid = (state_q == ST_DMA);
  assign cpu_rdata  = mem_rdata;
  assign dma_rdata  = mem_rdata;

  assign dma_gnt   = dma_gnt_w;
  assign cpu_stall = cpu_req & ~cpu_gnt;
  assign stall_cnt = stall_cnt_q;

  always_comb begin
    mem_addr  = dma_gnt_w ? dma_addr  : cpu_addr;
    mem_wdata = dma_gnt_w ? dma_wdata : cpu_wdata;
    if (cpu_gnt)        mem_wb = cpu_wb;
    else if (dma_gnt_w) mem_wb = dma_wb;
    else                mem_wb = '0;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed, table-driven bench for mem_port_arbiter.
module tb_mem_port_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        cpu_req, dma_req, dma_lock, stall_clr;
  logic [31:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata;
  logic [3:0]  cpu_wb, dma_wb;
  logic        cpu_stall, cpu_rvalid, dma_gnt, dma_rvalid;
  logic [31:0] cpu_rdata, dma_rdata, mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wb;
  logic [15:0] stall_cnt;

  logic        cpu_stall_1, cpu_rvalid_1, dma_gnt_1, dma_rvalid_1;
  logic [31:0] cpu_rdata_1, dma_rdata_1, mem_addr_1, mem_wdata_1;
  logic [3:0]  mem_wb_1;
  logic [15:0] stall_cnt_1;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  mem_port_arbiter #(.MEMORY_WIDTH(32), .MAX_BURST(8)) u_dut (
    .clock(clock), .reset(reset),
    .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_wb(cpu_wb),
    .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .dma_req(dma_req), .dma_lock(dma_lock), .dma_addr(dma_addr), .dma_wdata(dma_wdata), .dma_wb(dma_wb),
    .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wb(mem_wb), .mem_rdata(mem_rdata),
    .stall_cnt(stall_cnt), .stall_clr(stall_clr)
  );

  mem_port_arbiter #(.MEMORY_WIDTH(32), .MAX_BURST(1)) u_dut1 (
    .clock(clock), .reset(reset),
    .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_wb(cpu_wb),
    .cpu_stall(cpu_stall_1), .cpu_rvalid(cpu_rvalid_1), .cpu_rdata(cpu_rdata_1),
    .dma_req(dma_req), .dma_lock(dma_lock), .dma_addr(dma_addr), .dma_wdata(dma_wdata), .dma_wb(dma_wb),
    .dma_gnt(dma_gnt_1), .dma_rvalid(dma_rvalid_1), .dma_rdata(dma_rdata_1),
    .mem_addr(mem_addr_1), .mem_wdata(mem_wdata_1), .mem_wb(mem_wb_1), .mem_rdata(mem_rdata),
    .stall_cnt(stall_cnt_1), .stall_clr(stall_clr)
  );

  // RAM model with exactly one cycle of read latency.
  logic [31:0] ram [0:255];
  always @(posedge clock) begin
    for (int b = 0; b < 4; b++)
      if (mem_wb[b]) ram[mem_addr[9:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
    mem_rdata <= ram[mem_addr[9:2]];
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    cpu_req = 0; dma_req = 0; dma_lock = 0; stall_clr = 0;
    cpu_addr = 32'h1000; cpu_wdata = 32'h1111_1111; cpu_wb = 4'hA;
    dma_addr = 32'h2000; dma_wdata = 32'h2222_2222; dma_wb = 4'h5;
  endtask

  task automatic apply_reset();
    reset = 0;
    drive_idle();
    repeat (2) @(negedge clock);
    reset = 1;
  endtask

  // own: 0 = no grant, 1 = CPU, 2 = DMA
  typedef struct {
    logic       c, d, l;
    logic [1:0] own;
    logic       crv, drv;
  } vec_t;
  vec_t vecs [13];

  initial begin
    int stalls, cyc, gaps;
    logic exp_d, exp_d1, s_now;

    vecs[0]  = '{1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 1'b1, 1'b0, 2'd1, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 1'b1, 1'b0, 2'd2, 1'b1, 1'b0};
    vecs[3]  = '{1'b1, 1'b1, 1'b0, 2'd1, 1'b0, 1'b1};
    vecs[4]  = '{1'b1, 1'b1, 1'b0, 2'd2, 1'b1, 1'b0};
    vecs[5]  = '{1'b0, 1'b1, 1'b1, 2'd2, 1'b0, 1'b1};
    vecs[6]  = '{1'b1, 1'b1, 1'b1, 2'd2, 1'b0, 1'b1};
    vecs[7]  = '{1'b1, 1'b0, 1'b1, 2'd1, 1'b0, 1'b1};
    vecs[8]  = '{1'b0, 1'b1, 1'b1, 2'd2, 1'b1, 1'b0};
    vecs[9]  = '{1'b1, 1'b1, 1'b0, 2'd1, 1'b0, 1'b1};
    vecs[10] = '{1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0};
    vecs[11] = '{1'b1, 1'b1, 1'b0, 2'd2, 1'b0, 1'b0};
    vecs[12] = '{1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1};

    // Outputs while reset is held with both requesters active.
    reset = 0;
    drive_idle();
    cpu_req = 1; dma_req = 1; dma_lock = 1;
    @(negedge clock); #1;
    check("rst_dma_gnt", dma_gnt, 0);
    check("rst_cpu_stall", cpu_stall, 1);
    check("rst_mem_wb", mem_wb, 0);
    check("rst_cpu_rvalid", cpu_rvalid, 0);
    check("rst_dma_rvalid", dma_rvalid, 0);
    check("rst_stall_cnt", stall_cnt, 0);

    apply_reset();
    for (int i = 0; i < 13; i++) begin
      @(negedge clock);
      cpu_req = vecs[i].c; dma_req = vecs[i].d; dma_lock = vecs[i].l;
      #1;
      check($sformatf("vec%0d_dma_gnt", i), dma_gnt, vecs[i].own == 2);
      check($sformatf("vec%0d_cpu_stall", i), cpu_stall, vecs[i].c && vecs[i].own != 1);
      check($sformatf("vec%0d_mem_wb", i), mem_wb, vecs[i].own == 1 ? 4'hA : vecs[i].own == 2 ? 4'h5 : 4'h0);
      check($sformatf("vec%0d_mem_addr", i), mem_addr, vecs[i].own == 2 ? 32'h2000 : 32'h1000);
      check($sformatf("vec%0d_cpu_rvalid", i), cpu_rvalid, vecs[i].crv);
      check($sformatf("vec%0d_dma_rvalid", i), dma_rvalid, vecs[i].drv);
    end
    check("vec_stall_cnt", stall_cnt, 4);

    // Locked DMA burst, CPU joins on the 3rd cycle; MAX_BURST=1 copy must alternate.
    apply_reset();
    for (int k = 1; k <= 18; k++) begin
      @(negedge clock);
      dma_req = 1; dma_lock = 1; cpu_req = (k >= 3);
      #1;
      exp_d  = (k <= 8) || (k >= 10 && k <= 17);
      exp_d1 = (k <= 2) || (k % 2 == 0);
      check($sformatf("burst%0d_dma_gnt", k), dma_gnt, exp_d);
      check($sformatf("burst%0d_cpu_stall", k), cpu_stall, (k >= 3) && exp_d);
      check($sformatf("mb1_burst%0d_dma_gnt", k), dma_gnt_1, exp_d1);
    end
    check("burst_stall_cnt", stall_cnt, 14);

    // Reset asserted mid-burst.
    @(negedge clock);
    cpu_req = 0;
    #1 check("midrst_pre_gnt", dma_gnt, 1);
    @(negedge clock); #1;
    check("midrst_pre_rvalid", dma_rvalid, 1);
    check("midrst_pre_gnt2", dma_gnt, 1);
    reset = 0;
    #1;
    check("midrst_dma_gnt", dma_gnt, 0);
    check("midrst_dma_rvalid", dma_rvalid, 0);
    check("midrst_cpu_rvalid", cpu_rvalid, 0);
    check("midrst_mem_wb", mem_wb, 0);
    @(negedge clock);
    reset = 1; dma_req = 0; dma_lock = 0;
    #1 check("postrst_dma_rvalid", dma_rvalid, 0);
    @(negedge clock); #1;
    check("postrst_dma_rvalid2", dma_rvalid, 0);
    check("postrst_cpu_rvalid2", cpu_rvalid, 0);

    // Long locked DMA run with no CPU: continuous grants, burst count saturates.
    apply_reset();
    gaps = 0;
    for (int i = 0; i < 514; i++) begin
      @(negedge clock);
      dma_req = 1; dma_lock = 1;
      #1;
      if (!dma_gnt) gaps++;
    end
    check("long_dma_gaps", gaps, 0);
    @(negedge clock);
    cpu_req = 1;
    #1;
    check("long_sat_dma_gnt", dma_gnt, 0);
    check("long_sat_cpu_stall", cpu_stall, 0);

    // CPU write then read back.
    apply_reset();
    @(negedge clock);
    cpu_req = 1; cpu_addr = 32'h100; cpu_wdata = 32'hDEADBEEF; cpu_wb = 4'hF;
    #1;
    check("wr_cpu_stall", cpu_stall, 0);
    check("wr_mem_wb", mem_wb, 4'hF);
    check("wr_mem_addr", mem_addr, 32'h100);
    @(negedge clock);
    cpu_wb = 4'h0;
    #1 check("wr_cpu_rvalid", cpu_rvalid, 1);
    @(negedge clock);
    cpu_req = 0;
    #1;
    check("rd_cpu_rvalid", cpu_rvalid, 1);
    check("rd_cpu_rdata", cpu_rdata, 32'hDEADBEEF);
    check("rd_dma_rvalid", dma_rvalid, 0);
    @(negedge clock); #1;
    check("rd_cpu_rvalid_off", cpu_rvalid, 0);

    // Stall counter saturation and clear.
    apply_reset();
    @(negedge clock);
    cpu_req = 1; dma_req = 1; dma_lock = 1;
    stalls = 0; cyc = 0;
    while (stalls < 70000 && cyc < 90000) begin
      #1;
      if (cpu_stall) stalls++;
      cyc++;
      @(negedge clock);
    end
    #1;
    check("sat_loop_bound", stalls >= 70000, 1);
    check("sat_stall_cnt", stall_cnt, 16'hFFFF);
    stall_clr = 1;
    @(negedge clock); #1;
    check("clr_stall_cnt", stall_cnt, 0);
    stall_clr = 0;
    s_now = cpu_stall;
    @(negedge clock); #1;
    check("clr_then_count", stall_cnt, {15'd0, s_now});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter MEMORY_WIDTH, default 32, data width of all data buses.
REQ-002 SHALL have parameter MAX_BURST, default 8, maximum consecutive locked DMA grants while the CPU waits (legal range 1..255).
REQ-003 SHALL have port clock  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  reset, asynchronous and active-low (0 = in reset).
REQ-005 SHALL have ports cpu_req  input  1, cpu_addr  input  32, cpu_wdata  input  MEMORY_WIDTH, cpu_wb  input  MEMORY_WIDTH/8  (CPU access request, address, write data, byte write enables).
REQ-006 SHALL have ports cpu_stall  output  1, cpu_rvalid  output  1, cpu_rdata  output  MEMORY_WIDTH  (CPU stall, read-data valid, read data).
REQ-007 SHALL have ports dma_req  input  1, dma_lock  input  1, dma_addr  input  32, dma_wdata  input  MEMORY_WIDTH, dma_wb  input  MEMORY_WIDTH/8  (DMA request, burst lock, address, write data, byte enables).
REQ-008 SHALL have ports dma_gnt  output  1, dma_rvalid  output  1, dma_rdata  output  MEMORY_WIDTH.
REQ-009 SHALL have ports mem_addr  output  32, mem_wdata  output  MEMORY_WIDTH, mem_wb  output  MEMORY_WIDTH/8, mem_rdata  input  MEMORY_WIDTH  (shared RAM port; RAM read latency exactly 1 cycle).
REQ-010 SHALL have ports stall_cnt  output  16  (saturating CPU stall-cycle count) and stall_clr  input  1  (synchronous clear of stall_cnt).

Function
REQ-011 SHALL keep FSM state in {IDLE, CPU, DMA}, recording the owner of the previous cycle's grant (IDLE = no grant).
REQ-012 SHALL keep a 1-bit round-robin pointer last_winner (CPU/DMA), updated on every granted cycle, held otherwise.
REQ-013 SHALL keep an 8-bit burst_cnt: set to 1 on a DMA grant whose previous state is not DMA, incremented on each consecutive DMA grant, saturating at MAX_BURST, and cleared on any non-DMA cycle.
REQ-014 SHALL compute grants combinationally each cycle, at most one grant per cycle, with priority:
 - (a) state==DMA, dma_lock=1, dma_req=1, and (cpu_req=0 or burst_cnt<MAX_BURST) -> DMA;
 - (b) else both requesting -> the requester that is not last_winner;
 - (c) else the single requester;
 - (d) else none.
REQ-015 SHALL drive dma_gnt = DMA granted this cycle; cpu_stall = cpu_req AND NOT CPU-granted.
REQ-016 SHALL route mem_addr/mem_wdata/mem_wb from the granted requester; with no grant, mem_wb SHALL be all-zero and mem_addr/mem_wdata SHALL hold the CPU's values.
REQ-017 SHALL register the grant owner as rd_owner; cpu_rvalid = (rd_owner==CPU), dma_rvalid = (rd_owner==DMA), exactly one cycle after the grant, for reads and writes alike.
REQ-018 SHALL pass mem_rdata to both cpu_rdata and dma_rdata combinationally; only the matching rvalid qualifies them.
REQ-019 SHALL increment stall_cnt each cycle cpu_stall=1, saturating at 16'hFFFF; stall_clr=1 SHALL set it to 0 that cycle, taking precedence over increment.
REQ-020 SHALL let a request withdrawn in the same cycle it would be granted get no grant; requesters SHALL hold address/data stable while requesting without grant.
REQ-021 SHALL, when dma_lock drops mid-burst, arbitrate the next cycle by rule (b)/(c) with last_winner=DMA (CPU wins on contention).
REQ-022 SHALL, with MAX_BURST=1, give a locked DMA at most one grant while the CPU waits, i.e. strict alternation under contention.

Reset
REQ-023 SHALL, while reset=0, force state=IDLE, last_winner=DMA (CPU wins the first contention), burst_cnt=0, rd_owner=none, stall_cnt=0.
REQ-024 SHALL, during reset, drive dma_gnt=0, cpu_rvalid=0, dma_rvalid=0, mem_wb=0, and cpu_stall=cpu_req.
REQ-025 SHALL abort a burst when reset asserts mid-burst; no rvalid SHALL follow for grants issued before reset.

Verification
REQ-026 SHALL cover: after reset, cpu_req=dma_req=1 same cycle -> CPU granted first, DMA next, then alternating; stall_cnt counts CPU-losing cycles.
REQ-027 SHALL cover: DMA lock burst of 20 words, cpu_req=1 from its 3rd cycle, MAX_BURST=8 -> 8 consecutive dma_gnt, 1 CPU grant, DMA resumes with burst_cnt=1.
REQ-028 SHALL cover: DMA locked, cpu_req=0 throughout, 300 cycles -> dma_gnt continuous, burst_cnt saturated at 8, no gaps.
REQ-029 SHALL cover: CPU write 0xDEADBEEF wb=4'hF at 0x100, then read 0x100 -> cpu_rvalid 1 cycle after read grant with cpu_rdata=0xDEADBEEF, dma_rvalid=0.
REQ-030 SHALL cover: 70000 contended stall cycles -> stall_cnt=16'hFFFF; stall_clr pulse -> 0 next cycle; reset asserted mid-burst -> all grants/rvalids 0 asynchronously.
